obj_trajectory: RTL and testbench
=================================

// Module: obj_trajectory
// PURPOSE
//  Per-frame motion engine for one sprite (fruit). It sits directly upstream of displayObj and drives its posx/posy inputs.
//  On launch it flies a gravity parabola in fixed point, updated once per video frame (VS falling edge).
//  Handles wall, ceiling and floor boundaries; reports exit below the screen (done) and accepts a slice/kill.
// PARAMETERS
//  SCREEN_W   640  visible width, px
//  SCREEN_H   480  visible height, px
//  FRAC_BITS  4    fractional bits of position/velocity (velocity unit = 2^-FRAC_BITS px/frame)
//  GRAVITY    2    signed vy increment per frame, velocity units
// PORTS
//  clk        in   1   system clock (same domain as displayObj clk)
//  rst        in   1   synchronous, active-high reset
//  vs         in   1   VS from VGA (active-low sync pulse), same clock tree
//  launch     in   1   1-cycle request; honoured only in IDLE
//  launch_x   in   10  start x, integer px (left edge)
//  launch_vx  in   8   signed start vx
//  launch_vy  in   8   signed start vy (negative = upward)
//  kill       in   1   1-cycle slice; aborts flight
//  width      in   10  sprite width, px
//  height     in   9   sprite height, px
//  posx       out  10  integer x to displayObj
//  posy       out  9   integer y to displayObj
//  active     out  1   1 while in FLY
//  done       out  1   1-cycle pulse on exit below the screen
// BEHAVIOUR
//  Reset: posx=0, posy=0, active=0, done=0, state=IDLE, vs_q=1, px/py/vx/vy=0.
//  Frame tick: tick = vs_q & ~vs, where vs_q is vs registered each clk. It is one pulse per frame.
//  Internal state:
//   - px: signed, 12 integer bits + FRAC_BITS.
//   - py: signed, 11 integer bits + FRAC_BITS.
//   - vx, vy: signed 8-bit.
//   - posx/posy are the registered integer parts, truncated toward -inf.
//  IDLE:
//   - launch loads px=launch_x, py=SCREEN_H-height (fraction 0), vx, vy.
//   - It sets active=1 and enters FLY next cycle.
//   - posx/posy update in that same load cycle.
//   - A tick in the load cycle causes no motion; the first update happens on the next tick.
//   - Outside the load cycle, ticks are ignored in IDLE.
//  FLY, on each tick:
//   - npx = px+vx; npy = py+vy.
//   - vy <= sat8(vy+GRAVITY), clamped to [-128,127].
//  FLY boundaries, checked on npx/npy in the same tick, results registered together:
//   - Floor exit: int(npy) >= SCREEN_H -> IDLE, active=0, done=1 for one cycle. posx/posy hold their last in-screen values.
//   - Ceiling: int(npy) < 0 -> py=0 and vy=0. Gravity is not added this tick.
//   - Walls: int(npx) < 0 clamps px=0. int(npx) > SCREEN_W-width clamps px=SCREEN_W-width.
//     Wall handling depends on WALL_BOUNCE_EN (see CONFIGURATION).
//   - Negation of vx=-128 saturates to +127.
//  Kill:
//   - In FLY it forces IDLE next cycle with active=0 and done=0.
//   - Kill beats exit when both occur in the same cycle.
//   - Kill in IDLE has no effect.
//  launch in FLY is ignored; there is no restart.
//  Latency: posx/posy and done are valid 1 clk after the tick.
//  rst mid-flight returns everything to reset values next edge.
// CONFIGURATION
//  WALL_BOUNCE_EN defined: at a side wall, clamp px and set vx=-vx. Flight continues.
//  WALL_BOUNCE_EN undefined: a side-wall hit is treated as exit (IDLE, done pulse, posx/posy hold).
// TESTING
//  1. rst=1 for 2 clk -> posx=0, posy=0, active=0, done=0. A tick does nothing.
//  2. launch x=100, vx=16, vy=-64, w=30, h=20.
//     -> Load cycle: posx=100, posy=460.
//     -> Tick 1: posx=101, posy=456.
//     -> Tick 2: posx=102, posy=452.
//  3. Continue case 2 ticks until int(npy) >= 480.
//     -> done high exactly 1 clk, active=0.
//     -> Later ticks leave posx/posy unchanged.
//  4. launch x=605, vx=127, w=30.
//     -> Tick 1 with WALL_BOUNCE_EN: posx=610, vx=-127.
//     -> Tick 1 without it: done pulse.
//  5. h=300, vy=-128 (posy=180) -> posy reaches 0, vy=0. Next tick posy=0, then it descends.
//  6. kill on the exit tick -> active=0, done stays 0.
//     launch during FLY is ignored.
//     launch and tick in the same IDLE cycle -> no motion until the next tick.

Source files
------------

// File: rtl/obj_trajectory.sv
// Per-frame gravity-parabola motion engine for one sprite, feeding displayObj posx/posy.
// Build option: define WALL_BOUNCE_EN to reflect off the side walls instead of exiting there.
module obj_trajectory #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int FRAC_BITS = 4,
  parameter int GRAVITY   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vs,
  input  logic       launch,
  input  logic [9:0] launch_x,
  input  logic [7:0] launch_vx,
  input  logic [7:0] launch_vy,
  input  logic       kill,
  input  logic [9:0] width,
  input  logic [8:0] height,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       active,
  output logic       done
);
  localparam int PXW = 12 + FRAC_BITS;
  localparam int PYW = 11 + FRAC_BITS;
  localparam int CW  = PXW + 2;

  typedef enum logic {IDLE = 1'b0, FLY = 1'b1} state_t;
  state_t state_reg, state_next;

  logic                  vs_q_reg;
  logic                  tick;
  logic signed [PXW-1:0] px_reg, px_next;
  logic signed [PYW-1:0] py_reg, py_next;
  logic signed [7:0]     vx_reg, vx_next;
  logic signed [7:0]     vy_reg, vy_next;
  logic [9:0]            posx_reg, posx_next;
  logic [8:0]            posy_reg, posy_next;
  logic                  done_reg, done_next;

  logic signed [CW-1:0]  npx, npy, npx_int, npy_int, right_lim;
  logic signed [8:0]     vy_grav;
  logic signed [7:0]     vy_grav_sat, vx_neg;
  logic                  hit_floor, hit_ceil, hit_left, hit_right, exit_now;

  assign tick = vs_q_reg & ~vs;

  // Candidate position computed in a wider signed space so no boundary test can wrap.
  assign npx       = CW'(px_reg) + CW'(vx_reg);
  assign npy       = CW'(py_reg) + CW'(vy_reg);
  assign npx_int   = npx >>> FRAC_BITS;
  assign npy_int   = npy >>> FRAC_BITS;
  assign right_lim = CW'(SCREEN_W) - $signed(CW'(width));

  assign hit_floor = npy_int >= CW'(SCREEN_H);
  assign hit_ceil  = npy[CW-1];
  assign hit_left  = npx[CW-1];
  assign hit_right = npx_int > right_lim;

`ifdef WALL_BOUNCE_EN
  assign exit_now = hit_floor;
`else
  assign exit_now = hit_floor | hit_left | hit_right;
`endif

  assign vy_grav = 9'(vy_reg) + 9'(GRAVITY);

  always_comb begin
    if (vy_grav > 9'sd127) begin
      vy_grav_sat = 8'sh7f;
    end else if (vy_grav < -9'sd128) begin
      vy_grav_sat = 8'sh80;
    end else begin
      vy_grav_sat = vy_grav[7:0];
    end
  end

  // -(-128) does not fit in 8 bits, so it pins to +127.
  assign vx_neg = (vx_reg == 8'sh80) ? 8'sh7f : -vx_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (launch) state_next = FLY;
      FLY:     if (kill || (tick && exit_now)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    px_next   = px_reg;
    py_next   = py_reg;
    vx_next   = vx_reg;
    vy_next   = vy_reg;
    posx_next = posx_reg;
    posy_next = posy_reg;
    done_next = 1'b0;
    if (state_reg == IDLE) begin
      if (launch) begin
        px_next   = PXW'({launch_x, {FRAC_BITS{1'b0}}});
        py_next   = PYW'(SCREEN_H - int'(height)) <<< FRAC_BITS;
        vx_next   = $signed(launch_vx);
        vy_next   = $signed(launch_vy);
        posx_next = launch_x;
        posy_next = 9'(SCREEN_H - int'(height));
      end
    end else if (!kill && tick) begin
      if (exit_now) begin
        done_next = 1'b1;
      end else begin
        px_next = PXW'(npx);
        py_next = PYW'(npy);
        vy_next = vy_grav_sat;
        if (hit_ceil) begin
          py_next = '0;
          vy_next = '0;
        end
        if (hit_left) begin
          px_next = '0;
          vx_next = vx_neg;
        end else if (hit_right) begin
          px_next = PXW'(right_lim <<< FRAC_BITS);
          vx_next = vx_neg;
        end
        posx_next = px_next[FRAC_BITS +: 10];
        posy_next = py_next[FRAC_BITS +: 9];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q_reg <= 1'b1;
      px_reg   <= '0;
      py_reg   <= '0;
      vx_reg   <= '0;
      vy_reg   <= '0;
      posx_reg <= '0;
      posy_reg <= '0;
      done_reg <= 1'b0;
    end else begin
      vs_q_reg <= vs;
      px_reg   <= px_next;
      py_reg   <= py_next;
      vx_reg   <= vx_next;
      vy_reg   <= vy_next;
      posx_reg <= posx_next;
      posy_reg <= posy_next;
      done_reg <= done_next;
    end
  end

  always_comb begin
    active = (state_reg == FLY);
    done   = done_reg;
    posx   = posx_reg;
    posy   = posy_reg;
  end

endmodule

// File: tb/tb_obj_trajectory.sv
// Bench for obj_trajectory: directed flight scenarios plus random launches/frames/kills,
// checked every cycle against an integer-arithmetic model of the flight rules.
module tb_obj_trajectory;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs = 1'b1;
  logic       launch = 1'b0;
  logic       kill = 1'b0;
  logic [9:0] launch_x = '0;
  logic [7:0] launch_vx = '0;
  logic [7:0] launch_vy = '0;
  logic [9:0] width = 10'd30;
  logic [8:0] height = 9'd20;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       active;
  logic       done;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Model state: positions/velocities in 1/16 px units
  int m_px = 0, m_py = 0, m_vx = 0, m_vy = 0, m_posx = 0, m_posy = 0;
  bit m_fly = 1'b0, m_done = 1'b0, m_vsq = 1'b1;

  int  hit, exit_i;
  bit  seen;
  logic rv, rl, rk;
  int  rw;

  obj_trajectory dut (
    .clk(clk), .rst(rst), .vs(vs), .launch(launch), .launch_x(launch_x),
    .launch_vx(launch_vx), .launch_vy(launch_vy), .kill(kill), .width(width),
    .height(height), .posx(posx), .posy(posy), .active(active), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor16(input int a);
    if (a >= 0) return a / 16;
    return -((-a + 15) / 16);
  endfunction

  task automatic model_step();
    int  nx, ny, ix, iy, lim;
    bit  tk, ex, wall;
    m_done = 1'b0;
    if (rst) begin
      m_fly = 1'b0; m_posx = 0; m_posy = 0; m_vsq = 1'b1;
      m_px = 0; m_py = 0; m_vx = 0; m_vy = 0;
    end else begin
      tk = m_vsq && !vs;
      m_vsq = vs;
      if (!m_fly) begin
        if (launch) begin
          m_px = int'(launch_x) * 16;
          m_py = (480 - int'(height)) * 16;
          m_vx = int'($signed(launch_vx));
          m_vy = int'($signed(launch_vy));
          m_posx = int'(launch_x);
          m_posy = 480 - int'(height);
          m_fly = 1'b1;
        end
      end else if (kill) begin
        m_fly = 1'b0;
      end else if (tk) begin
        nx = m_px + m_vx;
        ny = m_py + m_vy;
        ix = floor16(nx);
        iy = floor16(ny);
        lim = 640 - int'(width);
        wall = (ix < 0) || (ix > lim);
`ifdef WALL_BOUNCE_EN
        ex = (iy >= 480);
`else
        ex = (iy >= 480) || wall;
`endif
        if (ex) begin
          m_fly = 1'b0;
          m_done = 1'b1;
        end else begin
          if (iy < 0) begin
            ny = 0;
            m_vy = 0;
          end else begin
            m_vy = (m_vy + 2 > 127) ? 127 : m_vy + 2;
          end
          if (wall) begin
            nx = (ix < 0) ? 0 : lim * 16;
            m_vx = (m_vx == -128) ? 127 : -m_vx;
          end
          m_px = nx;
          m_py = ny;
          m_posx = floor16(nx);
          m_posy = floor16(ny);
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (checking) begin
      check("posx", int'(posx), m_posx);
      check("posy", int'(posy), m_posy);
      check("active", int'(active), int'(m_fly));
      check("done", int'(done), int'(m_done));
    end
  end

  task automatic cyc(input logic v, input logic l, input logic k);
    vs = v; launch = l; kill = k;
    @(posedge clk);
    #2;
  endtask

  task automatic set_launch(input int x, input int vx, input int vy, input int w, input int h);
    launch_x = 10'(x); launch_vx = 8'(vx); launch_vy = 8'(vy);
    width = 10'(w); height = 9'(h);
  endtask

  initial begin
    // Reset and idle behaviour
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    checking = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    check("rst_posx", int'(posx), 0);
    check("rst_posy", int'(posy), 0);
    check("rst_active", int'(active), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("idle_tick_active", int'(active), 0);
    check("idle_tick_posx", int'(posx), 0);

    // Basic launch and first two frames
    set_launch(100, 16, -64, 30, 20);
    cyc(1'b1, 1'b1, 1'b0);
    check("load_posx", int'(posx), 100);
    check("load_posy", int'(posy), 460);
    check("load_active", int'(active), 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("t1_posx", int'(posx), 101);
    check("t1_posy", int'(posy), 456);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("t2_posx", int'(posx), 102);
    check("t2_posy", int'(posy), 452);
    cyc(1'b1, 1'b0, 1'b0);

    // Fly on until the floor exit; x advances exactly 1 px per frame
    seen = 1'b0; exit_i = 0;
    for (int i = 3; i <= 300 && !seen; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (done) begin
        seen = 1'b1;
        exit_i = i;
        check("exit_active", int'(active), 0);
        check("exit_posx_hold", int'(posx), 100 + i - 1);
      end
      cyc(1'b1, 1'b0, 1'b0);
      if (seen) check("done_one_cycle", int'(done), 0);
    end
    check("exit_seen", int'(seen), 1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("after_exit_posx", int'(posx), 100 + exit_i - 1);

    // Right wall
    set_launch(605, 127, -64, 30, 20);
    cyc(1'b1, 1'b1, 1'b0);
    check("wall_load_posx", int'(posx), 605);
    cyc(1'b0, 1'b0, 1'b0);
`ifdef WALL_BOUNCE_EN
    check("wall_clamp_posx", int'(posx), 610);
    check("wall_active", int'(active), 1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("bounce_posx", int'(posx), 602);
    cyc(1'b1, 1'b0, 1'b1);
    check("wall_kill_active", int'(active), 0);
`else
    check("wall_done", int'(done), 1);
    check("wall_active", int'(active), 0);
    check("wall_posx_hold", int'(posx), 605);
    cyc(1'b1, 1'b0, 1'b0);
`endif

    // Ceiling: hand-computed hit on frame 29, then slow descent
    set_launch(100, 0, -128, 30, 300);
    cyc(1'b1, 1'b1, 1'b0);
    check("ceil_load_posy", int'(posy), 180);
    hit = 0;
    for (int i = 1; i <= 40 && hit == 0; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (posy == 9'd0) hit = i;
      cyc(1'b1, 1'b0, 1'b0);
    end
    check("ceil_tick", hit, 29);
    cyc(1'b0, 1'b0, 1'b0);
    check("ceil_next_posy", int'(posy), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    check("ceil_descend_posy", int'(posy), 1);
    cyc(1'b1, 1'b0, 1'b1);

    // Kill on the exit frame wins
    set_launch(100, 0, 127, 30, 1);
    cyc(1'b1, 1'b1, 1'b0);
    check("kx_load_posy", int'(posy), 479);
    cyc(1'b0, 1'b0, 1'b1);
    check("kx_active", int'(active), 0);
    check("kx_done", int'(done), 0);
    check("kx_posy", int'(posy), 479);
    cyc(1'b1, 1'b0, 1'b0);

    // Launch while flying is ignored
    set_launch(200, 0, 0, 30, 20);
    cyc(1'b1, 1'b1, 1'b0);
    set_launch(300, 16, 0, 30, 20);
    cyc(1'b1, 1'b1, 1'b0);
    check("relaunch_posx", int'(posx), 200);
    cyc(1'b0, 1'b0, 1'b0);
    check("relaunch_tick_posx", int'(posx), 200);
    check("relaunch_tick_posy", int'(posy), 460);
    cyc(1'b1, 1'b0, 1'b1);

    // Launch and tick in the same idle cycle
    set_launch(50, 16, 0, 30, 20);
    cyc(1'b0, 1'b1, 1'b0);
    check("lt_posx", int'(posx), 50);
    check("lt_posy", int'(posy), 460);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("lt_first_posx", int'(posx), 51);
    cyc(1'b1, 1'b0, 1'b1);

    // Random frames, launches, kills and occasional resets
    for (int n = 0; n < 20000; n++) begin
      rv = ($urandom_range(0, 5) != 0);
      rl = ($urandom_range(0, 29) == 0);
      rk = ($urandom_range(0, 199) == 0);
      if (rl) begin
        rw = $urandom_range(1, 200);
        set_launch($urandom_range(0, 640 - rw), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), rw, $urandom_range(1, 480));
        if ($urandom_range(0, 7) == 0) launch_vx = 8'h80;
      end
      rst = ($urandom_range(0, 1999) == 0);
      cyc(rv, rl, rk);
    end
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
